// File: rtl/intellitec_pkg.sv
// Shared types and constants for the Intellitec two-zone shed scheduler.
package intellitec_pkg;

    localparam int unsigned NUM_ZONES  = 2;
    localparam int unsigned ZONE_FRONT = 0;
    localparam int unsigned ZONE_REAR  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MINRUN = 2'd1,
        RUN    = 2'd2,
        LOCK   = 2'd3
    } zone_state_t;

    function automatic logic is_active(input zone_state_t s);
        return (s == MINRUN) || (s == RUN);
    endfunction

endpackage

// File: rtl/intellitec_shed_scheduler_if.sv
// Frame-level request/status bundle between the scheduler and its environment.
interface intellitec_shed_scheduler_if;
    import intellitec_pkg::*;

    logic                 frame_tick;
    logic [NUM_ZONES-1:0] demand;
    logic                 budget;
    logic [NUM_ZONES-1:0] force_shed;
    logic [NUM_ZONES-1:0] shed;
    logic [NUM_ZONES-1:0] running;
    logic [NUM_ZONES-1:0] lockout;

    modport master (
        output frame_tick, demand, budget, force_shed,
        input  shed, running, lockout
    );

    modport slave (
        input  frame_tick, demand, budget, force_shed,
        output shed, running, lockout
    );

endinterface

// File: rtl/intellitec_zone_fsm.sv
// One zone's run/lockout FSM with its down-timer; advances only on tick.
// INTELLITEC_SHED_PWRUP_LOCK_EN selects a LOCK reset state instead of IDLE.
module intellitec_zone_fsm
    import intellitec_pkg::*;
#(
    parameter int unsigned MIN_ON  = 3,
    parameter int unsigned MIN_OFF = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        demand,
    input  logic        grant,
    input  logic        preempt,
    input  logic        force_shed,
    output zone_state_t state,
    output zone_state_t state_next
);

    localparam logic [CNT_W-1:0] OnLoad  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] OffLoad = CNT_W'(MIN_OFF - 1);

`ifdef INTELLITEC_SHED_PWRUP_LOCK_EN
    localparam zone_state_t      RstState = LOCK;
    localparam logic [CNT_W-1:0] RstTimer = OffLoad;
`else
    localparam zone_state_t      RstState = IDLE;
    localparam logic [CNT_W-1:0] RstTimer = '0;
`endif

    zone_state_t      state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (demand && grant && !force_shed) begin
                        state_d = MINRUN;
                        timer_d = OnLoad;
                    end
                end
                MINRUN: begin
                    // Override beats the minimum run time.
                    if (force_shed) begin
                        state_d = LOCK;
                        timer_d = OffLoad;
                    end else if (timer_q == '0) begin
                        state_d = RUN;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (force_shed || preempt || !demand) begin
                        state_d = LOCK;
                        timer_d = OffLoad;
                    end
                end
                LOCK: begin
                    if (timer_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RstState;
            timer_q <= RstTimer;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign state      = state_q;
    assign state_next = state_d;

endmodule

// File: rtl/intellitec_shed_scheduler.sv
// Two-zone compressor/load scheduler: grant/preempt arbiter, round-robin pointer
// and registered shed/running/lockout outputs. Option: INTELLITEC_SHED_PWRUP_LOCK_EN.
module intellitec_shed_scheduler
    import intellitec_pkg::*;
#(
    parameter int unsigned MIN_ON  = 3,
    parameter int unsigned MIN_OFF = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    intellitec_shed_scheduler_if.slave  bus
);

`ifdef INTELLITEC_SHED_PWRUP_LOCK_EN
    localparam logic [NUM_ZONES-1:0] RstLock = '1;
`else
    localparam logic [NUM_ZONES-1:0] RstLock = '0;
`endif

    zone_state_t          state      [NUM_ZONES];
    zone_state_t          state_next [NUM_ZONES];
    logic [NUM_ZONES-1:0] active, in_run, eligible, run_next, lock_next;
    logic [NUM_ZONES-1:0] grant, preempt;
    logic [NUM_ZONES-1:0] shed_q, running_q, lockout_q;
    logic                 rr_q, rr_d;

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        intellitec_zone_fsm #(
            .MIN_ON (MIN_ON),
            .MIN_OFF(MIN_OFF),
            .CNT_W  (CNT_W)
        ) u_fsm (
            .clock     (clock),
            .reset     (reset),
            .tick      (bus.frame_tick),
            .demand    (bus.demand[z]),
            .grant     (grant[z]),
            .preempt   (preempt[z]),
            .force_shed(bus.force_shed[z]),
            .state     (state[z]),
            .state_next(state_next[z])
        );
    end

    always_comb begin
        for (int z = 0; z < NUM_ZONES; z++) begin
            active[z]    = is_active(state[z]);
            in_run[z]    = (state[z] == RUN);
            eligible[z]  = (state[z] == IDLE) && bus.demand[z] && !bus.force_shed[z];
            run_next[z]  = is_active(state_next[z]);
            lock_next[z] = (state_next[z] == LOCK);
        end
    end

    // Single-zone budget: only start a zone when nothing else is on.
    always_comb begin
        grant = '0;
        rr_d  = rr_q;
        if (bus.budget) begin
            grant = eligible;
        end else if (active == '0) begin
            if (&eligible) begin
                grant = rr_q ? 2'b10 : 2'b01;
            end else begin
                grant = eligible;
            end
        end
        if (bus.frame_tick && !bus.budget && (grant != '0)) begin
            rr_d = grant[ZONE_FRONT];
        end
    end

    // Budget dropped with both zones on: shed a zone that has finished its minimum run.
    always_comb begin
        preempt = '0;
        if (!bus.budget && (&active)) begin
            if (&in_run) begin
                preempt[ZONE_REAR] = 1'b1;
            end else begin
                preempt = in_run;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q      <= 1'b0;
            shed_q    <= '1;
            running_q <= '0;
            lockout_q <= RstLock;
        end else begin
            rr_q      <= rr_d;
            shed_q    <= ~run_next | bus.force_shed;
            running_q <= run_next;
            lockout_q <= lock_next;
        end
    end

    assign bus.shed    = shed_q;
    assign bus.running = running_q;
    assign bus.lockout = lockout_q;

endmodule

// File: tb/tb_intellitec_shed_scheduler.sv
// Directed bench for intellitec_shed_scheduler (MIN_ON=3, MIN_OFF=4) with a
// scoreboard of hand-derived expected outputs per clock step.
module tb_intellitec_shed_scheduler;
    import intellitec_pkg::*;

    typedef struct {
        string      tag;
        logic [1:0] shed;
        logic [1:0] running;
        logic [1:0] lockout;
    } exp_t;

`ifdef INTELLITEC_SHED_PWRUP_LOCK_EN
    localparam logic [1:0] RstLock = 2'b11;
`else
    localparam logic [1:0] RstLock = 2'b00;
`endif

    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    intellitec_shed_scheduler_if bus ();

    intellitec_shed_scheduler #(
        .MIN_ON (3),
        .MIN_OFF(4),
        .CNT_W  (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] es, input logic [1:0] er,
                                 input logic [1:0] el);
        check({tag, ".shed"}, bus.shed, es);
        check({tag, ".running"}, bus.running, er);
        check({tag, ".lockout"}, bus.lockout, el);
    endtask

    // One clock: drive inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input string tag, input logic tk, input logic [1:0] dem, input logic bud,
                        input logic [1:0] frc, input logic [1:0] es, input logic [1:0] er,
                        input logic [1:0] el);
        exp_t e;
        e.tag = tag; e.shed = es; e.running = er; e.lockout = el;
        sb.push_back(e);
        @(negedge clock);
        bus.frame_tick = tk;
        bus.demand     = dem;
        bus.budget     = bud;
        bus.force_shed = frc;
        @(posedge clock);
        #1;
        bus.frame_tick = 1'b0;
        e = sb.pop_front();
        check_outputs(e.tag, e.shed, e.running, e.lockout);
    endtask

    initial begin
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.demand     = 2'b00;
        bus.budget     = 1'b0;
        bus.force_shed = 2'b00;
        #12;
        check_outputs("reset", 2'b11, 2'b00, RstLock);
        @(negedge clock);
        reset = 1'b0;

`ifdef INTELLITEC_SHED_PWRUP_LOCK_EN
        step("pwrup1", 1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b11);
        step("pwrup2", 1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b11);
        step("pwrup3", 1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b11);
        step("pwrup4", 1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b00);
`endif

        // Round-robin contention from reset: zone 0 first.
        step("rr1",    1, 2'b11, 0, 2'b00, 2'b10, 2'b01, 2'b00);
        step("between",0, 2'b00, 0, 2'b00, 2'b10, 2'b01, 2'b00);
        step("rr2",    1, 2'b11, 0, 2'b00, 2'b10, 2'b01, 2'b00);
        step("rr3",    1, 2'b11, 0, 2'b00, 2'b10, 2'b01, 2'b00);
        step("rr4",    1, 2'b11, 0, 2'b00, 2'b10, 2'b01, 2'b00);
        step("rr5",    1, 2'b10, 0, 2'b00, 2'b11, 2'b00, 2'b01);
        step("rr6",    1, 2'b10, 0, 2'b00, 2'b01, 2'b10, 2'b01);
        step("rr7",    1, 2'b10, 0, 2'b00, 2'b01, 2'b10, 2'b01);
        step("rr8",    1, 2'b10, 0, 2'b00, 2'b01, 2'b10, 2'b01);
        step("rr9",    1, 2'b10, 0, 2'b00, 2'b01, 2'b10, 2'b00);
        step("rr10",   1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b10);
        step("rr11",   1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b10);
        step("rr12",   1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b10);
        step("rr13",   1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b10);
        step("rr14",   1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b00);
        step("rr15",   1, 2'b11, 0, 2'b00, 2'b10, 2'b01, 2'b00);

        // Demand drops during MINRUN: zone keeps running until RUN, then stops.
        step("minrun2",1, 2'b00, 0, 2'b00, 2'b10, 2'b01, 2'b00);
        step("minrun3",1, 2'b00, 0, 2'b00, 2'b10, 2'b01, 2'b00);
        step("run",    1, 2'b00, 0, 2'b00, 2'b10, 2'b01, 2'b00);
        step("stop",   1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b01);

        // Short-cycle guard: demand back immediately, grant only on the 5th tick.
        step("sc1",    1, 2'b01, 0, 2'b00, 2'b11, 2'b00, 2'b01);
        step("sc2",    1, 2'b01, 0, 2'b00, 2'b11, 2'b00, 2'b01);
        step("sc3",    1, 2'b01, 0, 2'b00, 2'b11, 2'b00, 2'b01);
        step("sc4",    1, 2'b01, 0, 2'b00, 2'b11, 2'b00, 2'b00);
        step("sc5",    1, 2'b01, 0, 2'b00, 2'b10, 2'b01, 2'b00);

        // Force override mid-frame during MINRUN.
        step("frc_mid",0, 2'b01, 0, 2'b01, 2'b11, 2'b01, 2'b00);
        step("frc_tk", 1, 2'b01, 0, 2'b01, 2'b11, 2'b00, 2'b01);
        step("frc_l2", 1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b01);
        step("frc_l3", 1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b01);
        step("frc_l4", 1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b01);
        step("frc_end",1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b00);

        // Budget drop with both zones in RUN: zone 1 is preempted.
        step("both1",  1, 2'b11, 1, 2'b00, 2'b00, 2'b11, 2'b00);
        step("both2",  1, 2'b11, 1, 2'b00, 2'b00, 2'b11, 2'b00);
        step("both3",  1, 2'b11, 1, 2'b00, 2'b00, 2'b11, 2'b00);
        step("both4",  1, 2'b11, 1, 2'b00, 2'b00, 2'b11, 2'b00);
        step("bdrop",  1, 2'b11, 0, 2'b00, 2'b10, 2'b01, 2'b10);
        step("bdrop2", 1, 2'b11, 0, 2'b00, 2'b10, 2'b01, 2'b10);

        // Asynchronous reset while zone 0 runs.
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_outputs("async_rst", 2'b11, 2'b00, RstLock);
        @(negedge clock);
        reset = 1'b0;
`ifdef INTELLITEC_SHED_PWRUP_LOCK_EN
        step("post_rst", 1, 2'b01, 0, 2'b00, 2'b11, 2'b00, 2'b11);
`else
        step("post_rst", 1, 2'b01, 0, 2'b00, 2'b10, 2'b01, 2'b00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
